// File: rtl/l15_req_arb_if.sv
// Request/L1.5 handshake bundle for the L1.5 request arbiter.
// master = requesters plus L1.5 side, slave = the arbiter.
interface l15_req_arb_if #(
    parameter int unsigned NR_REQ    = 3,
    parameter int unsigned PAYLOAD_W = 192
);
    localparam int unsigned ID_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [NR_REQ-1:0]           req_valid_i;
    logic [NR_REQ-1:0]           req_is_store_i;
    logic [NR_REQ*PAYLOAD_W-1:0] req_payload_i;
    logic [NR_REQ-1:0]           req_ready_o;
    logic                        l15_val_o;
    logic [PAYLOAD_W-1:0]        l15_payload_o;
    logic [ID_W-1:0]             l15_req_id_o;
    logic                        l15_header_ack_i;
    logic                        store_ack_i;
    logic                        stores_empty_o;
    logic                        ack_err_o;

    modport master (
        output req_valid_i, req_is_store_i, req_payload_i, l15_header_ack_i, store_ack_i,
        input  req_ready_o, l15_val_o, l15_payload_o, l15_req_id_o, stores_empty_o, ack_err_o
    );

    modport slave (
        input  req_valid_i, req_is_store_i, req_payload_i, l15_header_ack_i, store_ack_i,
        output req_ready_o, l15_val_o, l15_payload_o, l15_req_id_o, stores_empty_o, ack_err_o
    );
endinterface

// File: rtl/l15_req_arb.sv
// Round-robin arbiter funnelling icache/dcache requests to the L1.5, with
// an outstanding-store credit counter used for fence drain.
module l15_req_arb #(
    parameter int unsigned NR_REQ         = 3,
    parameter int unsigned PAYLOAD_W      = 192,
    parameter int unsigned MAX_OUT_STORES = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    l15_req_arb_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUT_STORES + 1);
    localparam int unsigned ID_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [ID_W-1:0]      rr_q;
    logic [ID_W-1:0]      id_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 err_q;

    logic                 credit_ok_c;
    logic [NR_REQ-1:0]    elig_c;
    logic                 found_c;
    logic [ID_W:0]        scan_idx_c;
    logic [ID_W-1:0]      gnt_idx_c;
    logic                 grant_c;
    logic [NR_REQ-1:0]    ready_c;
    logic [PAYLOAD_W-1:0] payload_sel_c;
    logic                 store_sel_c;
    logic                 inc_c;
    logic                 dec_c;

    assign credit_ok_c = (cnt_q < CNT_W'(MAX_OUT_STORES));
    assign elig_c      = bus.req_valid_i & (~bus.req_is_store_i | {NR_REQ{credit_ok_c}});

    // First eligible requester scanning upward from rr_q with wrap-around
    always_comb begin
        found_c    = 1'b0;
        gnt_idx_c  = '0;
        scan_idx_c = '0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            scan_idx_c = {1'b0, rr_q} + (ID_W+1)'(k);
            if (scan_idx_c >= (ID_W+1)'(NR_REQ)) begin
                scan_idx_c = scan_idx_c - (ID_W+1)'(NR_REQ);
            end
            if (!found_c && elig_c[scan_idx_c[ID_W-1:0]]) begin
                found_c   = 1'b1;
                gnt_idx_c = scan_idx_c[ID_W-1:0];
            end
        end
    end

    always_comb begin
        payload_sel_c = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            if (gnt_idx_c == ID_W'(i)) begin
                payload_sel_c = bus.req_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign store_sel_c = bus.req_is_store_i[gnt_idx_c];

    // Next state and grant; reset suppresses the combinational grant
    always_comb begin
        state_d = state_q;
        grant_c = 1'b0;
        ready_c = '0;
        case (state_q)
            IDLE: begin
                if (found_c && !rst_i) begin
                    grant_c            = 1'b1;
                    ready_c[gnt_idx_c] = 1'b1;
                    state_d            = SEND;
                end
            end
            SEND: begin
                if (bus.l15_header_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inc_c = grant_c & store_sel_c;
    assign dec_c = bus.store_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_q      <= '0;
            id_q      <= '0;
            payload_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_c) begin
                id_q      <= gnt_idx_c;
                payload_q <= payload_sel_c;
                rr_q      <= (gnt_idx_c == ID_W'(NR_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
            end
            // An ack with nothing outstanding is a protocol error, never an underflow
            if (inc_c && !dec_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (dec_c && !inc_c && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (dec_c && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready_o    = ready_c;
    assign bus.l15_val_o      = (state_q == SEND);
    assign bus.l15_payload_o  = payload_q;
    assign bus.l15_req_id_o   = id_q;
    assign bus.stores_empty_o = (cnt_q == '0);
    assign bus.ack_err_o      = err_q;
endmodule

// File: tb/tb_l15_req_arb.sv
// Randomized scoreboard bench for l15_req_arb: a transaction-level model
// predicts each cycle's outputs, a monitor pops and compares them.
module tb_l15_req_arb;
    localparam int unsigned NR   = 3;
    localparam int unsigned PW   = 192;
    localparam int unsigned MAXS = 7;
    localparam int unsigned ID_W = 2;

    typedef struct {
        logic [NR-1:0]   ready;
        logic            val;
        logic [ID_W-1:0] id;
        logic [PW-1:0]   payload;
        logic            empty;
        logic            err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l15_req_arb_if #(.NR_REQ(NR), .PAYLOAD_W(PW)) bus ();

    l15_req_arb #(.NR_REQ(NR), .PAYLOAD_W(PW), .MAX_OUT_STORES(MAXS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: what the L1.5 port should be showing
    bit          m_busy;
    int          m_id;
    logic [PW-1:0] m_pay;
    int          m_rr;
    int          m_cnt;
    bit          m_err;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One cycle of stimulus; the model predicts outputs before the next rising edge
    task automatic drive(input logic r, input logic [NR-1:0] v, input logic [NR-1:0] st,
                         input bit hack, input bit sack);
        exp_t e;
        int   g;
        int   c;
        bit   inc;
        @(negedge clk);
        rst                  = r;
        bus.req_valid_i      = v;
        bus.req_is_store_i   = st;
        bus.l15_header_ack_i = hack;
        bus.store_ack_i      = sack;
        for (int i = 0; i < int'(NR*PW/32); i++) bus.req_payload_i[i*32 +: 32] = $urandom();
        if (r) begin
            m_busy = 0; m_id = 0; m_pay = '0; m_rr = 0; m_cnt = 0; m_err = 0;
        end
        e.val     = m_busy;
        e.id      = ID_W'(m_id);
        e.payload = m_pay;
        e.empty   = (m_cnt == 0);
        e.err     = m_err;
        e.ready   = '0;
        g = -1;
        if (!r && !m_busy) begin
            for (int k = 0; k < int'(NR); k++) begin
                c = (m_rr + k) % NR;
                if (g < 0 && v[c] && (!st[c] || m_cnt < int'(MAXS))) g = c;
            end
        end
        if (g >= 0) e.ready[g] = 1'b1;
        exp_q.push_back(e);
        if (!r) begin
            inc = (g >= 0) && st[g];
            if (sack && m_cnt == 0) m_err = 1;
            if (g >= 0) begin
                m_busy = 1;
                m_id   = g;
                m_pay  = bus.req_payload_i[g*PW +: PW];
                m_rr   = (g + 1) % NR;
            end else if (m_busy && hack) begin
                m_busy = 0;
            end
            if (inc && !sack) m_cnt++;
            else if (sack && !inc && m_cnt > 0) m_cnt--;
        end
    endtask

    // Monitor: compare DUT outputs against the predicted record for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req_ready", PW'(bus.req_ready_o), PW'(e.ready));
                chk("l15_val", PW'(bus.l15_val_o), PW'(e.val));
                chk("l15_req_id", PW'(bus.l15_req_id_o), PW'(e.id));
                chk("l15_payload", bus.l15_payload_o, e.payload);
                chk("stores_empty", PW'(bus.stores_empty_o), PW'(e.empty));
                chk("ack_err", PW'(bus.ack_err_o), PW'(e.err));
            end
        end
    end

    initial begin
        logic [NR-1:0] rv;
        logic [NR-1:0] rs;
        bus.req_valid_i      = '0;
        bus.req_is_store_i   = '0;
        bus.req_payload_i    = '0;
        bus.l15_header_ack_i = 1'b0;
        bus.store_ack_i      = 1'b0;
        m_busy = 0; m_id = 0; m_pay = '0; m_rr = 0; m_cnt = 0; m_err = 0;

        repeat (2) drive(1, '0, '0, 0, 0);
        // Single load held in SEND until acked
        drive(0, 3'b001, 3'b000, 0, 0);
        drive(0, 3'b000, 3'b000, 0, 0);
        drive(0, 3'b000, 3'b000, 0, 0);
        drive(0, 3'b000, 3'b000, 1, 0);
        repeat (2) drive(0, 3'b000, 3'b000, 0, 0);
        // Round robin with immediate acks
        repeat (8) drive(0, 3'b111, 3'b000, 1, 0);
        repeat (2) drive(0, 3'b000, 3'b000, 1, 0);
        // Store credits exhaust while the load keeps flowing; one ack frees a credit
        repeat (24) drive(0, 3'b101, 3'b100, 1, 0);
        drive(0, 3'b100, 3'b100, 1, 1);
        repeat (3) drive(0, 3'b100, 3'b100, 1, 0);
        repeat (2) drive(0, 3'b000, 3'b000, 1, 0);
        // Ack with nothing outstanding
        drive(1, '0, '0, 0, 0);
        drive(0, 3'b000, 3'b000, 0, 1);
        repeat (3) drive(0, 3'b000, 3'b000, 0, 0);
        // Store grant coinciding with a store ack at count 3
        drive(1, '0, '0, 0, 0);
        repeat (6) drive(0, 3'b100, 3'b100, 1, 0);
        drive(0, 3'b100, 3'b100, 1, 1);
        repeat (2) drive(0, 3'b000, 3'b000, 1, 0);
        // Reset pulsed while in SEND with four stores outstanding
        drive(1, '0, '0, 0, 0);
        repeat (7) drive(0, 3'b100, 3'b100, 1, 0);
        drive(1, 3'b111, 3'b000, 0, 0);
        drive(0, 3'b111, 3'b000, 1, 0);
        repeat (2) drive(0, 3'b000, 3'b000, 1, 0);
        // Random traffic
        repeat (3000) begin
            rv = NR'($urandom());
            rs = NR'($urandom());
            drive(($urandom_range(0, 199) == 0), rv, rs,
                  ($urandom_range(0, 9) < 6), (m_cnt > 0) && ($urandom_range(0, 9) < 2));
        end
        repeat (2) drive(0, '0, '0, 0, 0);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", PW'(exp_q.size()), PW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
